// File: rtl/hls_deadlock_pkg.sv
// Shared types and constants for the HLS deadlock monitor.
//   state_e   : global monitor state (idle / watching a pending block / blocked)
//   INFO_*    : per-channel status codes reported on axis_block_info
//   idx_width : width of an index able to address n channels (minimum 1)
package hls_deadlock_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWatch,
    StBlocked
  } state_e;

  localparam logic [1:0] INFO_CLEAR = 2'b00;
  localparam logic [1:0] INFO_PEND  = 2'b01;
  localparam logic [1:0] INFO_CONF  = 2'b11;

  function automatic int unsigned idx_width(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hls_deadlock_chan_cnt.sv
// One monitored channel: persistence counter plus pending/confirmed flags.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   raw_i               : raw block indication for this channel
//   thresh_i            : consecutive cycles needed to confirm (0 behaves as 1)
//   sticky_i            : hold confirmed until clear_i
//   clear_i             : drop counter and flags; raw_i ignored this cycle
//   pending_next_o      : pending flag value after the next edge
//   confirmed_next_o    : confirmed flag value after the next edge
//   pending_o           : registered pending flag
//   confirmed_o         : registered confirmed flag
module hls_deadlock_chan_cnt #(
  parameter int unsigned ThreshW = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               raw_i,
  input  logic [ThreshW-1:0] thresh_i,
  input  logic               sticky_i,
  input  logic               clear_i,
  output logic               pending_next_o,
  output logic               confirmed_next_o,
  output logic               pending_o,
  output logic               confirmed_o
);

  logic [ThreshW-1:0] cnt_q, cnt_d;
  logic               pending_q, pending_d;
  logic               confirmed_q, confirmed_d;
  logic [ThreshW:0]   cnt_inc;
  logic [ThreshW:0]   thresh_eff;
  logic               confirm_next;

  always_comb begin
    // One extra bit so a saturated counter still compares as max+1.
    cnt_inc      = {1'b0, cnt_q} + (ThreshW + 1)'(1);
    thresh_eff   = (thresh_i == '0) ? (ThreshW + 1)'(1) : {1'b0, thresh_i};
    confirm_next = raw_i & (cnt_inc >= thresh_eff);

    cnt_d       = cnt_q;
    pending_d   = pending_q;
    confirmed_d = confirmed_q;
    if (clear_i) begin
      cnt_d       = '0;
      pending_d   = 1'b0;
      confirmed_d = 1'b0;
    end else begin
      if (raw_i) begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_inc[ThreshW-1:0];
      end else begin
        cnt_d = '0;
      end
      pending_d   = raw_i;
      confirmed_d = confirm_next | (sticky_i & confirmed_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      confirmed_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      confirmed_q <= confirmed_d;
    end
  end

  assign pending_next_o   = pending_d;
  assign confirmed_next_o = confirmed_d;
  assign pending_o        = pending_q;
  assign confirmed_o      = confirmed_q;

endmodule

// File: rtl/hls_deadlock_axis_monitor.sv
// Deadlock monitor for HLS datapaths: watches AXIS block signals and sub-instance
// block/idle pairs, confirms a block after a programmable persistence, and reports
// per-channel status, the first offender and how long the block has lasted.
//   clock, reset_n   : clock, asynchronous active-low reset
//   axis_block_sigs  : per-channel AXIS block indications
//   inst_idle_sigs   : per-instance idle (masks the matching block)
//   inst_block_sigs  : per-instance block
//   cfg_threshold    : consecutive cycles to confirm (0 behaves as 1)
//   cfg_sticky       : hold confirmed state until clear
//   clear            : single-cycle pulse dropping all latched status
//   axis_block_info  : per channel {confirmed, pending} code
//   inst_block_info  : per-instance confirmed
//   block            : monitor is in the blocked state
//   first_valid      : first_idx holds a captured offender
//   first_idx        : lowest channel confirmed on entry to blocked (instances at N_AXIS+j)
//   stall_cycles     : cycles spent blocked, saturating
module hls_deadlock_axis_monitor
  import hls_deadlock_pkg::*;
#(
  parameter int unsigned N_AXIS   = 2,
  parameter int unsigned N_INST   = 1,
  parameter int unsigned THRESH_W = 16,
  parameter int unsigned STALL_W  = 32,
  localparam int unsigned N_INST_W = (N_INST == 0) ? 1 : N_INST,
  localparam int unsigned N_CH     = N_AXIS + N_INST,
  localparam int unsigned IDX_W    = idx_width(N_CH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_AXIS-1:0]     axis_block_sigs,
  input  logic [N_INST_W-1:0]   inst_idle_sigs,
  input  logic [N_INST_W-1:0]   inst_block_sigs,
  input  logic [THRESH_W-1:0]   cfg_threshold,
  input  logic                  cfg_sticky,
  input  logic                  clear,
  output logic [2*N_AXIS-1:0]   axis_block_info,
  output logic [N_INST_W-1:0]   inst_block_info,
  output logic                  block,
  output logic                  first_valid,
  output logic [IDX_W-1:0]      first_idx,
  output logic [STALL_W-1:0]    stall_cycles
);

  logic [N_CH-1:0] raw;
  logic [N_CH-1:0] pend_next, conf_next, pend_q, conf_q;

  state_e             state_q, state_d;
  logic               first_valid_q, first_valid_d;
  logic [IDX_W-1:0]   first_idx_q, first_idx_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [IDX_W-1:0]   lowest_idx;

  always_comb begin
    raw = '0;
    for (int i = 0; i < N_AXIS; i++) begin
      raw[i] = axis_block_sigs[i];
    end
    for (int j = 0; j < N_INST; j++) begin
      raw[N_AXIS+j] = inst_block_sigs[j] & ~inst_idle_sigs[j];
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_chan
    hls_deadlock_chan_cnt #(
      .ThreshW(THRESH_W)
    ) u_chan (
      .clk_i           (clock),
      .rst_ni          (reset_n),
      .raw_i           (raw[c]),
      .thresh_i        (cfg_threshold),
      .sticky_i        (cfg_sticky),
      .clear_i         (clear),
      .pending_next_o  (pend_next[c]),
      .confirmed_next_o(conf_next[c]),
      .pending_o       (pend_q[c]),
      .confirmed_o     (conf_q[c])
    );
  end

  // Priority encoder: scan downwards so the lowest set index wins.
  always_comb begin
    lowest_idx = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (conf_next[c]) lowest_idx = IDX_W'(c);
    end
  end

  always_comb begin
    state_d       = state_q;
    first_valid_d = first_valid_q;
    first_idx_d   = first_idx_q;
    stall_d       = stall_q;
    if (clear) begin
      state_d       = StIdle;
      first_valid_d = 1'b0;
      first_idx_d   = '0;
      stall_d       = '0;
    end else begin
      if (|conf_next) begin
        state_d = StBlocked;
      end else if (cfg_sticky && (state_q == StBlocked)) begin
        state_d = StBlocked;
      end else if (|pend_next) begin
        state_d = StWatch;
      end else begin
        state_d = StIdle;
      end

      if (state_d == StBlocked) begin
        if (state_q != StBlocked) begin
          first_valid_d = 1'b1;
          first_idx_d   = lowest_idx;
          stall_d       = STALL_W'(1);
        end else if (stall_q != '1) begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      first_valid_q <= 1'b0;
      first_idx_q   <= '0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      first_valid_q <= first_valid_d;
      first_idx_q   <= first_idx_d;
      stall_q       <= stall_d;
    end
  end

  // Status is masked outside blocked; only pending codes show through while watching.
  always_comb begin
    axis_block_info = '0;
    for (int i = 0; i < N_AXIS; i++) begin
      if (state_q == StBlocked) begin
        axis_block_info[2*i+:2] = conf_q[i] ? INFO_CONF : (pend_q[i] ? INFO_PEND : INFO_CLEAR);
      end else if ((state_q == StWatch) && pend_q[i]) begin
        axis_block_info[2*i+:2] = INFO_PEND;
      end
    end
    inst_block_info = '0;
    for (int j = 0; j < N_INST; j++) begin
      inst_block_info[j] = (state_q == StBlocked) & conf_q[N_AXIS+j];
    end
  end

  assign block        = (state_q == StBlocked);
  assign first_valid  = first_valid_q;
  assign first_idx    = first_idx_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hls_deadlock_axis_monitor.sv
module tb_hls_deadlock_axis_monitor;

  logic        clock;
  logic        reset_n;
  logic [1:0]  axis_block_sigs;
  logic [0:0]  inst_idle_sigs;
  logic [0:0]  inst_block_sigs;
  logic [15:0] cfg_threshold;
  logic        cfg_sticky;
  logic        clear;
  logic [3:0]  axis_block_info;
  logic [0:0]  inst_block_info;
  logic        block;
  logic        first_valid;
  logic [1:0]  first_idx;
  logic [31:0] stall_cycles;

  int n_vec  = 0;
  int n_miss = 0;

  hls_deadlock_axis_monitor #(
    .N_AXIS  (2),
    .N_INST  (1),
    .THRESH_W(16),
    .STALL_W (32)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs (inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs),
    .cfg_threshold  (cfg_threshold),
    .cfg_sticky     (cfg_sticky),
    .clear          (clear),
    .axis_block_info(axis_block_info),
    .inst_block_info(inst_block_info),
    .block          (block),
    .first_valid    (first_valid),
    .first_idx      (first_idx),
    .stall_cycles   (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  axis;
    logic        idle;
    logic        iblk;
    logic [15:0] thr;
    logic        sticky;
    logic        clr;
    logic        e_blk;
    logic [3:0]  e_ainfo;
    logic        e_iinfo;
    logic        e_fv;
    logic [1:0]  e_fidx;
    logic [31:0] e_stall;
  } vec_t;

  localparam int NumVec = 25;
  vec_t vecs[NumVec];

  function automatic vec_t mk(logic [1:0] axis, logic idle, logic iblk, logic [15:0] thr,
                              logic sticky, logic clr, logic e_blk, logic [3:0] e_ainfo,
                              logic e_iinfo, logic e_fv, logic [1:0] e_fidx,
                              logic [31:0] e_stall);
    vec_t v;
    v.axis = axis; v.idle = idle; v.iblk = iblk; v.thr = thr; v.sticky = sticky;
    v.clr = clr; v.e_blk = e_blk; v.e_ainfo = e_ainfo; v.e_iinfo = e_iinfo;
    v.e_fv = e_fv; v.e_fidx = e_fidx; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic check(input string name, input logic e_blk, input logic [3:0] e_ainfo,
                       input logic e_iinfo, input logic e_fv, input logic [1:0] e_fidx,
                       input logic [31:0] e_stall);
    n_vec++;
    if (block !== e_blk || axis_block_info !== e_ainfo || inst_block_info[0] !== e_iinfo ||
        first_valid !== e_fv || first_idx !== e_fidx || stall_cycles !== e_stall) begin
      n_miss++;
      $display("FAIL %s: got blk=%b ainfo=%b iinfo=%b fv=%b fidx=%0d stall=%0d, expected blk=%b ainfo=%b iinfo=%b fv=%b fidx=%0d stall=%0d",
               name, block, axis_block_info, inst_block_info[0], first_valid, first_idx,
               stall_cycles, e_blk, e_ainfo, e_iinfo, e_fv, e_fidx, e_stall);
    end
  endtask

  task automatic apply(input logic [1:0] axis, input logic idle, input logic iblk,
                       input logic [15:0] thr, input logic sticky, input logic clr);
    @(negedge clock);
    axis_block_sigs    = axis;
    inst_idle_sigs[0]  = idle;
    inst_block_sigs[0] = iblk;
    cfg_threshold      = thr;
    cfg_sticky         = sticky;
    clear              = clr;
    @(posedge clock);
    #1;
  endtask

  initial begin
    //             axis   id  ib  thr st  cl   blk ainfo    ii  fv  fidx stall
    vecs[0]  = mk(2'b01, 0, 0, 1, 0, 0,  1, 4'b0011, 0, 1, 0, 1);
    vecs[1]  = mk(2'b01, 0, 0, 1, 0, 0,  1, 4'b0011, 0, 1, 0, 2);
    vecs[2]  = mk(2'b01, 0, 0, 1, 0, 0,  1, 4'b0011, 0, 1, 0, 3);
    vecs[3]  = mk(2'b00, 0, 0, 1, 0, 0,  0, 4'b0000, 0, 1, 0, 3);
    vecs[4]  = mk(2'b10, 0, 0, 4, 0, 0,  0, 4'b0100, 0, 1, 0, 3);
    vecs[5]  = mk(2'b10, 0, 0, 4, 0, 0,  0, 4'b0100, 0, 1, 0, 3);
    vecs[6]  = mk(2'b10, 0, 0, 4, 0, 0,  0, 4'b0100, 0, 1, 0, 3);
    vecs[7]  = mk(2'b00, 0, 0, 4, 0, 0,  0, 4'b0000, 0, 1, 0, 3);
    vecs[8]  = mk(2'b10, 0, 0, 4, 0, 0,  0, 4'b0100, 0, 1, 0, 3);
    vecs[9]  = mk(2'b10, 0, 0, 4, 0, 0,  0, 4'b0100, 0, 1, 0, 3);
    vecs[10] = mk(2'b10, 0, 0, 4, 0, 0,  0, 4'b0100, 0, 1, 0, 3);
    vecs[11] = mk(2'b10, 0, 0, 4, 0, 0,  1, 4'b1100, 0, 1, 1, 1);
    vecs[12] = mk(2'b00, 0, 0, 4, 0, 0,  0, 4'b0000, 0, 1, 1, 1);
    vecs[13] = mk(2'b11, 0, 1, 1, 0, 0,  1, 4'b1111, 1, 1, 0, 1);
    vecs[14] = mk(2'b00, 1, 1, 1, 0, 0,  0, 4'b0000, 0, 1, 0, 1);
    vecs[15] = mk(2'b11, 1, 1, 1, 0, 0,  1, 4'b1111, 0, 1, 0, 1);
    vecs[16] = mk(2'b00, 0, 1, 1, 0, 0,  1, 4'b0000, 1, 1, 0, 2);
    vecs[17] = mk(2'b00, 0, 0, 1, 0, 0,  0, 4'b0000, 0, 1, 0, 2);
    vecs[18] = mk(2'b00, 0, 1, 1, 0, 0,  1, 4'b0000, 1, 1, 2, 1);
    vecs[19] = mk(2'b00, 0, 0, 1, 0, 0,  0, 4'b0000, 0, 1, 2, 1);
    vecs[20] = mk(2'b01, 0, 0, 1, 0, 1,  0, 4'b0000, 0, 0, 0, 0);
    vecs[21] = mk(2'b01, 0, 0, 1, 0, 0,  1, 4'b0011, 0, 1, 0, 1);
    vecs[22] = mk(2'b00, 0, 0, 1, 0, 0,  0, 4'b0000, 0, 1, 0, 1);
    vecs[23] = mk(2'b10, 0, 0, 0, 0, 0,  1, 4'b1100, 0, 1, 1, 1);
    vecs[24] = mk(2'b00, 0, 0, 0, 0, 0,  0, 4'b0000, 0, 1, 1, 1);

    reset_n = 1'b0;
    axis_block_sigs = '0; inst_idle_sigs = '0; inst_block_sigs = '0;
    cfg_threshold = 16'd1; cfg_sticky = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset", 0, 4'b0000, 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int k = 0; k < NumVec; k++) begin
      apply(vecs[k].axis, vecs[k].idle, vecs[k].iblk, vecs[k].thr, vecs[k].sticky, vecs[k].clr);
      check($sformatf("vec%0d", k), vecs[k].e_blk, vecs[k].e_ainfo, vecs[k].e_iinfo,
            vecs[k].e_fv, vecs[k].e_fidx, vecs[k].e_stall);
    end

    // Sticky, threshold 2: block survives the input dropping until clear.
    apply(2'b01, 0, 0, 2, 1, 0); check("sticky_pend", 0, 4'b0001, 0, 1, 1, 1);
    apply(2'b01, 0, 0, 2, 1, 0); check("sticky_conf", 1, 4'b0011, 0, 1, 0, 1);
    apply(2'b00, 0, 0, 2, 1, 0); check("sticky_hold1", 1, 4'b0011, 0, 1, 0, 2);
    apply(2'b00, 0, 0, 2, 1, 0); check("sticky_hold2", 1, 4'b0011, 0, 1, 0, 3);
    apply(2'b00, 0, 0, 2, 1, 1); check("sticky_clear", 0, 4'b0000, 0, 0, 0, 0);
    apply(2'b00, 0, 0, 2, 1, 0); check("post_clear", 0, 4'b0000, 0, 0, 0, 0);

    // Dropping sticky with raw low releases the held flag on the next edge.
    apply(2'b10, 0, 0, 1, 1, 0); check("tog_conf", 1, 4'b1100, 0, 1, 1, 1);
    apply(2'b00, 0, 0, 1, 1, 0); check("tog_hold", 1, 4'b1100, 0, 1, 1, 2);
    apply(2'b00, 0, 0, 1, 0, 0); check("tog_release", 0, 4'b0000, 0, 1, 1, 2);

    // 100 blocked cycles, then asynchronous reset between edges.
    apply(2'b01, 0, 0, 1, 0, 1);
    for (int k = 0; k < 100; k++) apply(2'b01, 0, 0, 1, 0, 0);
    check("stall100", 1, 4'b0011, 0, 1, 0, 100);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", 0, 4'b0000, 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hls_deadlock_axis_monitor.md
# hls_deadlock_axis_monitor

Parametrised deadlock monitor for HLS-generated datapath modules such as the IQ filter. It watches N_AXIS AXI-Stream block signals and N_INST sub-instance block/idle pairs, and requires a block to persist for a programmable number of cycles before flagging it. It reports per-channel pending/confirmed status, the first offender, and a stall-duration count. It has an optional sticky mode, so a transient deadlock remains visible to software until explicitly cleared. It sits beside the HLS core and feeds the debug/status register block.

## Interface
- N_AXIS, 2, number of AXIS block inputs (≥1)
- N_INST, 1, number of sub-instance block/idle pairs (≥0; 0 disables instance logic)
- THRESH_W, 16, width of persistence counters and threshold
- STALL_W, 32, width of stall-duration counter

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- axis_block_sigs  in  N_AXIS  per-channel AXIS block indication
- inst_idle_sigs  in  max(N_INST,1)  instance idle
- inst_block_sigs  in  max(N_INST,1)  instance block
- cfg_threshold  in  THRESH_W  consecutive cycles needed to confirm; 0 treated as 1
- cfg_sticky  in  1  1 = confirmed state held until clear
- clear  in  1  single-cycle pulse; drops all latched status
- axis_block_info  out  2*N_AXIS  per channel {confirmed, pending}: 00 clear, 01 pending, 11 confirmed
- inst_block_info  out  max(N_INST,1)  per-instance confirmed
- block  out  1  any channel confirmed
- first_valid  out  1  first_idx is valid
- first_idx  out  clog2(N_AXIS+N_INST)  lowest-index channel confirmed on entry to BLOCKED (instances indexed N_AXIS+j)
- stall_cycles  out  STALL_W  cycles spent in BLOCKED, saturating

## Operation
- Channel raw signals:
  - AXIS channel i raw = axis_block_sigs[i].
  - Instance j raw = inst_block_sigs[j] & ~inst_idle_sigs[j].
- Per-channel counter cnt:
  - raw=1: cnt <= sat(cnt+1), saturating at all-ones.
  - raw=0: cnt <= 0.
- pending = raw registered. confirm_next = raw & (cnt+1 ≥ max(cfg_threshold,1)); comparison uses the live threshold.
- confirmed flag:
  - Non-sticky: confirmed <= confirm_next.
  - Sticky: confirmed <= confirmed | confirm_next.
- Global FSM, states IDLE, WATCH, BLOCKED; next state is computed from next-cycle flags:
  - Any confirmed → BLOCKED.
  - Else any pending → WATCH.
  - Else IDLE.
  - In sticky mode BLOCKED exits only on clear.
- block = (state==BLOCKED).
- axis_block_info and inst_block_info are forced to 0 whenever block=0, with one exception: pending (01) codes are shown in WATCH.
- Entering BLOCKED:
  - first_idx latches the lowest-index confirming channel and first_valid is set.
  - stall_cycles loads 1, then increments each BLOCKED cycle, saturating.
  - first_idx and stall_cycles hold after leaving BLOCKED until the next entry or clear.
- clear has priority over all updates:
  - Counters, flags, first_valid and stall_cycles go to 0; state goes to IDLE.
  - Raw inputs asserted during the clear cycle are ignored; counting restarts the following cycle.
- Toggling cfg_sticky from 1 to 0 releases held flags on the next edge if their raw is low.

## Timing
- All outputs are registered. Reset value of every output is 0; state resets to IDLE.
- Latency at threshold 1: raw high sampled at edge k → block and info valid after edge k (one cycle).
- Latency at threshold T: raw continuously high for T edges → confirmed after the T-th edge. A single low cycle restarts the count.
- Non-sticky deassert: block falls one edge after all raw inputs go low.
- Multiple channels confirming on the same edge: first_idx is the lowest index.
- Counter saturation: the counter stays at max; confirmation persists.
- Asynchronous reset mid-operation clears everything immediately. Deassertion is synchronised externally.

## Structure
- Package hls_deadlock_pkg holds:
  - the state enum (IDLE/WATCH/BLOCKED);
  - info code constants INFO_CLEAR=2'b00, INFO_PEND=2'b01, INFO_CONF=2'b11;
  - an index-width function.
- Sub-module hls_deadlock_chan_cnt implements one channel's saturating counter, pending and confirmed flags, and the sticky/clear logic. It is instantiated N_AXIS+N_INST times via generate.
- The top level contains the FSM, the priority encoder for first_idx, and the stall counter.

## Test plan
- N_AXIS=2, threshold 1, non-sticky; axis_block_sigs=2'b01 for 3 cycles → block high after the first edge, axis_block_info=4'b0011, first_idx=0, stall_cycles=3; block low one edge after the input drops.
- Threshold 4; channel 1 high 3 cycles, low 1, high 4 → info 01 pending throughout the first burst and no block; block after the 4th cycle of the second burst, first_idx=1.
- Sticky, threshold 2; channel 0 high 2 cycles then low → block stays high and stall_cycles keeps counting; clear pulse → all outputs 0 next cycle.
- Both channels and instance 0 (idle=0) confirm on the same edge → first_idx=0; inst_block_info=1 only if inst_idle_sigs=0 (idle=1 masks it).
- clear asserted in the same cycle raw rises, threshold 1 → no block that edge; block asserts one edge later.
- Assert reset_n low mid-BLOCKED with stall_cycles=100 → all outputs 0 immediately, with no clock edge required.
